// File: rtl/pic_interrupt_sequencer.sv
// pic_interrupt_sequencer
// Control sequencer for an 8259A-style PIC in 8086 mode. It raises INT to the
// CPU and runs the two-pulse INTA acknowledge cycle. It owns the in-service
// register and issues IRR-clear strobes. It also services OCW2 EOI and
// priority commands and maintains the rotation pointer that the resolver uses.
//
// Ports
//   clk, reset                : system clock, synchronous active-high reset
//   interrupt[7:0]            : one-hot winning request from the resolver (or 0)
//   inta_n                    : CPU acknowledge, active low, already synchronized
//   vector_base[4:0]          : ICW2 T7..T3
//   auto_eoi, auto_rotate     : AEOI mode and rotate-in-AEOI mode
//   eoi_strobe                : one-cycle OCW2 command pulse
//   eoi_specific/rotate/is_eoi: OCW2 SL, R and EOI bits
//   eoi_level[2:0]            : OCW2 L2..L0
//   int_out                   : INT to CPU
//   isr[7:0]                  : in-service register
//   clear_irr[7:0]            : one-cycle strobe clearing the acknowledged IRR bit
//   priority_rotate[2:0]      : level that currently has highest priority
//   highest_level_in_service  : one-hot highest-priority ISR bit, 0 if empty
//   data_out[7:0], data_out_en: vector byte and bus drive enable
module pic_interrupt_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] interrupt,
   input  logic       inta_n,
   input  logic [4:0] vector_base,
   input  logic       auto_eoi,
   input  logic       auto_rotate,
   input  logic       eoi_strobe,
   input  logic       eoi_specific,
   input  logic       eoi_rotate,
   input  logic       eoi_is_eoi,
   input  logic [2:0] eoi_level,
   output logic       int_out,
   output logic [7:0] isr,
   output logic [7:0] clear_irr,
   output logic [2:0] priority_rotate,
   output logic [7:0] highest_level_in_service,
   output logic [7:0] data_out,
   output logic       data_out_en
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACK1  = 2'd1;
   localparam logic [1:0] ST_WAIT2 = 2'd2;
   localparam logic [1:0] ST_ACK2  = 2'd3;

   logic [1:0] state;
   logic [1:0] state_next;
   logic       prev_inta_n;
   logic       inta_fall;
   logic       inta_rise;
   logic [2:0] ack_level;
   logic       spurious;

   logic [2:0] interrupt_level;
   logic [2:0] hlis_level;
   logic [2:0] scan_idx;
   logic       scan_found;

   logic       ack_fall;
   logic       ack_done;
   logic [7:0] set_mask;
   logic       eoi_nonspec;
   logic       eoi_spec;
   logic       eoi_set_pri;
   logic       eoi_rot_valid;
   logic [7:0] eoi_clear_mask;
   logic [2:0] eoi_clear_level;
   logic       aeoi_clear;
   logic [7:0] aeoi_mask;
   logic [2:0] rotate_next;
   logic [7:0] isr_next;

   // Edge detection is done against the previous sample so each INTA pulse is
   // seen exactly once regardless of how many cycles it is held.
   assign inta_fall = prev_inta_n & ~inta_n;
   assign inta_rise = ~prev_inta_n & inta_n;

   // Binary encode of the resolver's one-hot request.
   always_comb begin
      interrupt_level = '0;
      for (int i = 0; i < 8; i++) begin
         if (interrupt[i]) interrupt_level = 3'(i);
      end
   end

   // Rotation-aware scan of the ISR: start at the current highest-priority
   // level and walk upward with wrap, stopping at the first set bit.
   always_comb begin
      highest_level_in_service = '0;
      hlis_level               = '0;
      scan_found               = 1'b0;
      scan_idx                 = '0;
      for (int i = 0; i < 8; i++) begin
         scan_idx = priority_rotate + 3'(i);
         if (!scan_found && isr[scan_idx]) begin
            highest_level_in_service[scan_idx] = 1'b1;
            hlis_level                         = scan_idx;
            scan_found                         = 1'b1;
         end
      end
   end

   // Acknowledge cycle sequencing: IDLE -> ACK1 on the first INTA fall,
   // WAIT2 on its rise, ACK2 on the second fall, back to IDLE on the second rise.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (inta_fall) state_next = ST_ACK1;
         ST_ACK1:  if (inta_rise) state_next = ST_WAIT2;
         ST_WAIT2: if (inta_fall) state_next = ST_ACK2;
         default:  if (inta_rise) state_next = ST_IDLE;
      endcase
   end

   // ISR and rotation update. EOI selection looks at the pre-update ISR, and
   // the set mask is OR-ed in last so a set beats a clear on the same bit.
   // An EOI rotate takes precedence over the AEOI rotate.
   always_comb begin
      ack_fall      = (state == ST_IDLE) && inta_fall;
      ack_done      = (state == ST_ACK2) && inta_rise;
      set_mask      = (ack_fall && (|interrupt)) ? (8'b1 << interrupt_level) : 8'b0;

      eoi_nonspec   = eoi_strobe & eoi_is_eoi & ~eoi_specific;
      eoi_spec      = eoi_strobe & eoi_is_eoi & eoi_specific;
      eoi_set_pri   = eoi_strobe & ~eoi_is_eoi & eoi_specific & eoi_rotate;
      eoi_rot_valid = eoi_strobe & eoi_is_eoi & eoi_rotate & (eoi_specific | (|isr));

      eoi_clear_mask = 8'b0;
      if (eoi_nonspec)   eoi_clear_mask = highest_level_in_service;
      else if (eoi_spec) eoi_clear_mask = 8'b1 << eoi_level;
      eoi_clear_level = eoi_specific ? eoi_level : hlis_level;

      aeoi_clear = ack_done & auto_eoi & ~spurious;
      aeoi_mask  = aeoi_clear ? (8'b1 << ack_level) : 8'b0;

      rotate_next = priority_rotate;
      if (eoi_rot_valid)                   rotate_next = eoi_clear_level + 3'd1;
      else if (eoi_set_pri)                rotate_next = eoi_level + 3'd1;
      else if (aeoi_clear && auto_rotate)  rotate_next = ack_level + 3'd1;

      isr_next = (isr & ~(eoi_clear_mask | aeoi_mask)) | set_mask;
   end

   // Registered state and outputs. The vector is driven only while in ACK2,
   // and a spurious acknowledge reports level 7 without touching the ISR.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         prev_inta_n     <= 1'b1;
         ack_level       <= '0;
         spurious        <= 1'b0;
         int_out         <= 1'b0;
         isr             <= '0;
         clear_irr       <= '0;
         priority_rotate <= '0;
         data_out        <= '0;
         data_out_en     <= 1'b0;
      end else begin
         state           <= state_next;
         prev_inta_n     <= inta_n;
         isr             <= isr_next;
         clear_irr       <= set_mask;
         priority_rotate <= rotate_next;
         int_out         <= (state_next == ST_IDLE) && (|interrupt);
         if (ack_fall) begin
            ack_level <= (|interrupt) ? interrupt_level : 3'd7;
            spurious  <= ~(|interrupt);
         end
         data_out_en <= (state_next == ST_ACK2);
         data_out    <= (state_next == ST_ACK2) ? {vector_base, ack_level} : 8'h00;
      end
   end

endmodule
